// File: rtl/ws2812_stream_tx.sv
// ws2812_stream_tx
// Serialises 24-bit GRB pixel words into the single-wire WS2812 LED waveform.
// Pixels arrive over a valid/ready stream into a one-entry holding register,
// which lets the next pixel follow the current one with no idle clocks.
// A frame ends with a latch gap that holds the line low for RST_CYC clocks.
//
// Ports
//   wb_clk_i      in   clock
//   wb_rst_ni     in   asynchronous active-low reset
//   enable_i      in   transmitter enable, only sampled in IDLE
//   pix_valid_i   in   pixel word valid
//   pix_ready_o   out  holding register empty
//   pix_data_i    in   {G,R,B}, bit 23 sent first
//   pix_last_i    in   last word of the frame, latch gap follows it
//   led_o         out  registered serial waveform
//   led_oeb_o     out  registered ~enable_i (pad output enable, active low)
//   busy_o        out  high whenever the FSM is not in IDLE
//   frame_done_o  out  one-cycle pulse on the last clock of the latch gap
//   underrun_o    out  one-cycle pulse when a mid-frame gap reaches RST_CYC
//   state_o       out  current FSM state (debug)
//
// Handshake: a word transfers on every rising edge where pix_valid_i and
// pix_ready_o are both high. pix_ready_o depends only on the holding register
// being empty, never on pix_valid_i, and the source must hold its word stable
// while valid is high and ready is low.

module ws2812_stream_tx #(
    parameter int T0H_CYC = 14,
    parameter int T1H_CYC = 28,
    parameter int BIT_CYC = 50,
    parameter int RST_CYC = 2000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        enable_i,
    input  logic        pix_valid_i,
    output logic        pix_ready_o,
    input  logic [23:0] pix_data_i,
    input  logic        pix_last_i,
    output logic        led_o,
    output logic        led_oeb_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        underrun_o,
    output logic [1:0]  state_o
);

    localparam int CNT_MAX = (BIT_CYC > RST_CYC) ? BIT_CYC : RST_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] BIT_END = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] RST_END = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] T0H     = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H     = CW'(T1H_CYC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [4:0]    bit_idx, bit_idx_nxt;
    logic [23:0]   sh, sh_nxt;
    logic          sh_last, sh_last_nxt;
    logic [23:0]   hold;
    logic          hold_last;
    logic          hold_full;
    logic          accept;
    logic          consume;
    logic          led_nxt;

    assign pix_ready_o = ~hold_full;
    assign accept      = pix_valid_i & ~hold_full;
    assign busy_o      = (state != IDLE);
    assign state_o     = state;

    // Next-state, counters, shifter and the two status pulses.
    // "consume" marks the cycle the shifter takes the holding register.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        bit_idx_nxt  = bit_idx;
        sh_nxt       = sh;
        sh_last_nxt  = sh_last;
        consume      = 1'b0;
        led_nxt      = 1'b0;
        frame_done_o = 1'b0;
        underrun_o   = 1'b0;

        case (state)
            IDLE: begin
                if (enable_i && hold_full) begin
                    consume     = 1'b1;
                    sh_nxt      = hold;
                    sh_last_nxt = hold_last;
                    bit_idx_nxt = 5'd23;
                    cnt_nxt     = '0;
                    state_nxt   = SHIFT;
                end
            end

            SHIFT: begin
                // High for the first T1H or T0H clocks of each bit period.
                led_nxt = (cnt < (sh[23] ? T1H : T0H));
                if (cnt == BIT_END) begin
                    cnt_nxt = '0;
                    if (bit_idx == 5'd0) begin
                        if (sh_last) begin
                            state_nxt = LATCH;
                        end else if (hold_full) begin
                            // Reload straight away so the next pixel's first
                            // bit follows with no idle clock.
                            consume     = 1'b1;
                            sh_nxt      = hold;
                            sh_last_nxt = hold_last;
                            bit_idx_nxt = 5'd23;
                        end else begin
                            state_nxt = GAP;
                        end
                    end else begin
                        sh_nxt      = {sh[22:0], 1'b0};
                        bit_idx_nxt = bit_idx - 5'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            GAP: begin
                // Arriving data wins over the underrun on the same clock.
                if (hold_full) begin
                    consume     = 1'b1;
                    sh_nxt      = hold;
                    sh_last_nxt = hold_last;
                    bit_idx_nxt = 5'd23;
                    cnt_nxt     = '0;
                    state_nxt   = SHIFT;
                end else if (cnt == RST_END) begin
                    underrun_o = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            LATCH: begin
                if (cnt == RST_END) begin
                    frame_done_o = 1'b1;
                    cnt_nxt      = '0;
                    state_nxt    = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= 5'd23;
            sh      <= '0;
            sh_last <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            sh      <= sh_nxt;
            sh_last <= sh_last_nxt;
        end
    end

    // Holding register. If a reload and a new accept land on the same edge,
    // the shifter takes the old word and the new one stays buffered.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            hold      <= '0;
            hold_last <= 1'b0;
            hold_full <= 1'b0;
        end else begin
            if (accept) begin
                hold      <= pix_data_i;
                hold_last <= pix_last_i;
            end
            hold_full <= (hold_full & ~consume) | accept;
        end
    end

    // Pad outputs. led_nxt is 0 outside SHIFT, so the line is low in IDLE.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            led_o     <= 1'b0;
            led_oeb_o <= 1'b1;
        end else begin
            led_o     <= led_nxt;
            led_oeb_o <= ~enable_i;
        end
    end

endmodule

// File: tb/tb_ws2812_stream_tx.sv
// tb_ws2812_stream_tx
// Directed bench for ws2812_stream_tx with small timing parameters
// (T0H=2, T1H=4, BIT=6, RST=10). A table of single-word frames is pushed and
// each bit period is compared against the waveform expected from the word's
// bits; hand-written sequences cover reset, back-to-back words, gap resume,
// reset mid-bit and enable gating.

module tb_ws2812_stream_tx;

    localparam int T0H = 2;
    localparam int T1H = 4;
    localparam int BIT = 6;
    localparam int RST = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_data;
    logic        pix_last;
    logic        led;
    logic        led_oeb;
    logic        busy;
    logic        frame_done;
    logic        underrun;
    logic [1:0]  state_dbg;

    int n_vec  = 0;
    int n_miss = 0;

    ws2812_stream_tx #(
        .T0H_CYC(T0H),
        .T1H_CYC(T1H),
        .BIT_CYC(BIT),
        .RST_CYC(RST)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .enable_i    (enable),
        .pix_valid_i (pix_valid),
        .pix_ready_o (pix_ready),
        .pix_data_i  (pix_data),
        .pix_last_i  (pix_last),
        .led_o       (led),
        .led_oeb_o   (led_oeb),
        .busy_o      (busy),
        .frame_done_o(frame_done),
        .underrun_o  (underrun),
        .state_o     (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [23:0] d, input logic l);
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = l;
        tick();
        pix_valid = 1'b0;
    endtask

    // Called on the sample holding the first clock of bit 23; returns one
    // sample past the last clock of bit 0.
    task automatic check_word(input logic [23:0] w, output int highs);
        logic exp;
        highs = 0;
        for (int b = 23; b >= 0; b--) begin
            for (int c = 0; c < BIT; c++) begin
                exp = (c < (w[b] ? T1H : T0H));
                chk($sformatf("led w%06h b%0d c%0d", w, b, c), {31'd0, led}, {31'd0, exp});
                if (led) highs++;
                tick();
            end
        end
    endtask

    // Called one clock into the low tail (LATCH or GAP count 1); checks the
    // rest of the RST-clock low period, the end pulse and the return to IDLE.
    task automatic check_tail(input logic exp_done, input logic exp_under);
        for (int i = 1; i < RST; i++) begin
            chk($sformatf("tail led %0d", i), {31'd0, led}, 32'd0);
            chk($sformatf("tail busy %0d", i), {31'd0, busy}, 32'd1);
            chk($sformatf("tail done %0d", i), {31'd0, frame_done},
                {31'd0, exp_done && (i == RST - 1)});
            chk($sformatf("tail underrun %0d", i), {31'd0, underrun},
                {31'd0, exp_under && (i == RST - 1)});
            tick();
        end
        chk("idle busy", {31'd0, busy}, 32'd0);
        chk("idle done", {31'd0, frame_done}, 32'd0);
        chk("idle underrun", {31'd0, underrun}, 32'd0);
        chk("idle ready", {31'd0, pix_ready}, 32'd1);
        chk("idle led", {31'd0, led}, 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [23:0] data;
        logic        last;
        int          exp_ones;
        logic        exp_done;
        logic        exp_under;
    } vec_t;

    vec_t vt[6];

    // ---------------- main sequence ----------------
    initial begin
        int hs;

        vt[0] = '{24'h800000, 1'b1,  1, 1'b1, 1'b0};
        vt[1] = '{24'hA5A5A5, 1'b1, 12, 1'b1, 1'b0};
        vt[2] = '{24'h123456, 1'b1,  9, 1'b1, 1'b0};
        vt[3] = '{24'hFFFFFF, 1'b1, 24, 1'b1, 1'b0};
        vt[4] = '{24'h000000, 1'b1,  0, 1'b1, 1'b0};
        vt[5] = '{24'h000001, 1'b0,  1, 1'b0, 1'b1};

        // reset with valid held high
        rst_n     = 1'b0;
        enable    = 1'b1;
        pix_valid = 1'b1;
        pix_data  = 24'hDEAD01;
        pix_last  = 1'b1;
        tick();
        tick();
        chk("rst led", {31'd0, led}, 32'd0);
        chk("rst oeb", {31'd0, led_oeb}, 32'd1);
        chk("rst ready", {31'd0, pix_ready}, 32'd1);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, frame_done}, 32'd0);
        chk("rst underrun", {31'd0, underrun}, 32'd0);
        pix_valid = 1'b0;
        rst_n     = 1'b1;
        chk("oeb before edge", {31'd0, led_oeb}, 32'd1);
        tick();
        chk("oeb after release", {31'd0, led_oeb}, 32'd0);
        chk("busy after release", {31'd0, busy}, 32'd0);

        // table of single-word frames
        for (int v = 0; v < 6; v++) begin
            push(vt[v].data, vt[v].last);
            chk($sformatf("v%0d ready after push", v), {31'd0, pix_ready}, 32'd0);
            tick();
            chk($sformatf("v%0d led at load", v), {31'd0, led}, 32'd0);
            chk($sformatf("v%0d busy at load", v), {31'd0, busy}, 32'd1);
            tick();
            check_word(vt[v].data, hs);
            chk($sformatf("v%0d high clocks", v), hs,
                vt[v].exp_ones * T1H + (24 - vt[v].exp_ones) * T0H);
            check_tail(vt[v].exp_done, vt[v].exp_under);
        end

        // back-to-back words, no idle clock at the boundary
        push(24'hFFFFFF, 1'b0);
        chk("b2b ready full", {31'd0, pix_ready}, 32'd0);
        pix_valid = 1'b1;
        pix_data  = 24'h000000;
        pix_last  = 1'b1;
        tick();
        chk("b2b ready drained", {31'd0, pix_ready}, 32'd1);
        tick();
        pix_valid = 1'b0;
        chk("b2b ready refilled", {31'd0, pix_ready}, 32'd0);
        check_word(24'hFFFFFF, hs);
        chk("b2b ready after reload", {31'd0, pix_ready}, 32'd1);
        chk("b2b busy at boundary", {31'd0, busy}, 32'd1);
        check_word(24'h000000, hs);
        chk("b2b second word highs", hs, 24 * T0H);
        check_tail(1'b1, 1'b0);

        // word arrives at gap clock 5: resume without underrun
        push(24'h0F0F0F, 1'b0);
        tick();
        tick();
        check_word(24'h0F0F0F, hs);
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("gap led %0d", i), {31'd0, led}, 32'd0);
            chk($sformatf("gap underrun %0d", i), {31'd0, underrun}, 32'd0);
            chk($sformatf("gap busy %0d", i), {31'd0, busy}, 32'd1);
            tick();
        end
        push(24'hC30081, 1'b1);
        chk("resume ready", {31'd0, pix_ready}, 32'd0);
        chk("resume underrun", {31'd0, underrun}, 32'd0);
        tick();
        chk("resume busy", {31'd0, busy}, 32'd1);
        chk("resume ready drained", {31'd0, pix_ready}, 32'd1);
        chk("resume led low", {31'd0, led}, 32'd0);
        tick();
        check_word(24'hC30081, hs);
        check_tail(1'b1, 1'b0);

        // reset in the middle of bit 12 with a word buffered
        push(24'hFFFFFF, 1'b0);
        pix_valid = 1'b1;
        pix_data  = 24'h123456;
        pix_last  = 1'b1;
        tick();
        tick();
        pix_valid = 1'b0;
        chk("mid ready full", {31'd0, pix_ready}, 32'd0);
        repeat (11 * BIT + 1) tick();
        chk("mid led high", {31'd0, led}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid rst led", {31'd0, led}, 32'd0);
        chk("mid rst ready", {31'd0, pix_ready}, 32'd1);
        chk("mid rst busy", {31'd0, busy}, 32'd0);
        chk("mid rst oeb", {31'd0, led_oeb}, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post rst busy", {31'd0, busy}, 32'd0);
        chk("post rst ready", {31'd0, pix_ready}, 32'd1);
        chk("post rst led", {31'd0, led}, 32'd0);
        push(24'h800000, 1'b1);
        tick();
        tick();
        check_word(24'h800000, hs);
        chk("post rst highs", hs, T1H + 23 * T0H);
        check_tail(1'b1, 1'b0);

        // enable low in IDLE holds a buffered word
        enable = 1'b0;
        tick();
        chk("dis oeb", {31'd0, led_oeb}, 32'd1);
        push(24'h55AA33, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("dis led %0d", i), {31'd0, led}, 32'd0);
            chk($sformatf("dis ready %0d", i), {31'd0, pix_ready}, 32'd0);
            chk($sformatf("dis busy %0d", i), {31'd0, busy}, 32'd0);
            tick();
        end
        enable = 1'b1;
        tick();
        chk("en load busy", {31'd0, busy}, 32'd1);
        chk("en load led", {31'd0, led}, 32'd0);
        chk("en load ready", {31'd0, pix_ready}, 32'd1);
        tick();
        check_word(24'h55AA33, hs);
        check_tail(1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
